// File: rtl/peak_pkg.sv
// Shared definitions for the peak table controller.
// Contents: table geometry, search length, FSM state enum and table entry type.
package peak_pkg;

  localparam int ENTRY_W       = 25;
  localparam int MAG_W         = 16;
  localparam int BIN_W         = ENTRY_W - MAG_W;
  localparam int DEPTH         = 16;
  localparam int CNT_W         = 5;
  localparam int SEARCH_CYCLES = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_INSERT,
    S_DUMP
  } state_t;

  // Matches the s_data/m_data bit layout: {bin[24:16], mag[15:0]}.
  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic [MAG_W-1:0] mag;
  } entry_t;

endpackage

// File: rtl/peak_table_ctrl.sv
// Peak table controller: keeps the 16 largest-magnitude samples of a frame,
// sorted in descending order, and streams them out on request.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   frame_start        - clears the table (only honoured when idle)
//   s_valid/s_ready    - candidate sample handshake, s_data = {bin, mag}
//   frame_end          - requests a readout of the current table
//   m_valid/m_ready    - readout handshake; m_data entry, m_index rank,
//                        m_last marks the final entry
//   count              - number of valid entries (0..16)
//   busy               - not idle, or a readout is pending
//   overrun            - sticky: a frame_start arrived while not idle
module peak_table_ctrl
  import peak_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [ENTRY_W-1:0] s_data,
  input  logic               frame_end,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ENTRY_W-1:0] m_data,
  output logic [3:0]         m_index,
  output logic               m_last,
  output logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               overrun
);

  state_t           state;
  entry_t           table_q [DEPTH];
  entry_t           sample_q;
  logic [CNT_W-1:0] lo_q;
  logic [CNT_W-1:0] hi_q;
  logic [2:0]       search_cnt;
  logic             pending_q;
  logic [3:0]       mid;
  logic             accept;
  logic             drop;

  assign s_ready = (state == S_IDLE) && !pending_q && !frame_start;
  assign busy    = (state != S_IDLE) || pending_q;
  assign accept  = s_valid && s_ready;

  // A full table only takes samples strictly larger than its current minimum.
  assign drop = (count == CNT_W'(DEPTH)) &&
                (s_data[MAG_W-1:0] <= table_q[DEPTH-1].mag);

  // Midpoint of [lo, hi); only used while lo < hi, so it always fits 0..15.
  assign mid = 4'((6'(lo_q) + 6'(hi_q)) >> 1);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      pending_q  <= 1'b0;
      overrun    <= 1'b0;
      sample_q   <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      search_cnt <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_index    <= '0;
      m_data     <= '0;
      // NOTE: the table is a register array, not a RAM, so it can be cleared
      // here; entries above count are never read out.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      pending_q <= pending_q | frame_end;

      if (frame_start && !(state == S_IDLE && !pending_q)) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pending_q) begin
            // A frame_end in this very cycle re-arms another readout.
            pending_q <= frame_end;
            state     <= S_DUMP;
            m_index   <= '0;
            if (count != '0) begin
              m_valid <= 1'b1;
              m_data  <= table_q[0];
              m_last  <= (count == CNT_W'(1));
            end
          end else if (frame_start) begin
            count <= '0;
          end else if (accept && !drop) begin
            sample_q   <= s_data;
            lo_q       <= '0;
            hi_q       <= count;
            search_cnt <= '0;
            state      <= S_SEARCH;
          end
        end

        S_SEARCH: begin
          // Converges on the first index whose magnitude is strictly smaller,
          // so equal magnitudes land behind existing entries.
          if (lo_q < hi_q) begin
            if (sample_q.mag > table_q[mid].mag) hi_q <= CNT_W'(mid);
            else                                 lo_q <= CNT_W'(mid) + CNT_W'(1);
          end
          search_cnt <= search_cnt + 3'd1;
          if (search_cnt == 3'(SEARCH_CYCLES - 1)) state <= S_INSERT;
        end

        S_INSERT: begin
          for (int i = DEPTH - 1; i >= 1; i--) begin
            if (CNT_W'(i) > lo_q) table_q[i] <= table_q[i-1];
          end
          if (lo_q < CNT_W'(DEPTH)) table_q[lo_q[3:0]] <= sample_q;
          if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
          state <= S_IDLE;
        end

        S_DUMP: begin
          if (!m_valid) begin
            state <= S_IDLE;
          end else if (m_ready) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              state   <= S_IDLE;
            end else begin
              m_index <= m_index + 4'd1;
              m_data  <= table_q[m_index + 4'd1];
              m_last  <= (CNT_W'(m_index) + CNT_W'(2) == count);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_table_ctrl.sv
// Self-checking bench for peak_table_ctrl: directed scenarios plus random
// traffic, compared against a sorted-queue model of the table.
module tb_peak_table_ctrl;
  import peak_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [24:0] s_data = '0;
  logic        frame_end = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [24:0] m_data;
  logic [3:0]  m_index;
  logic        m_last;
  logic [4:0]  count;
  logic        busy;
  logic        overrun;

  peak_table_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .frame_end(frame_end), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .count(count), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [24:0] model_q[$];   // expected table contents, index 0 = largest
  logic [24:0] expect_q[$];  // entries the current readout must still emit
  logic [24:0] got_q[$];     // entries actually handed over in the readout
  int          exp_idx = 0;
  bit          mon_en = 0;
  bit          sync = 0;
  bit          exp_overrun = 0;

  logic        prev_valid = 0;
  logic        prev_ready = 0;
  logic [31:0] prev_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic model_insert(input logic [24:0] e);
    int pos = model_q.size();
    for (int i = 0; i < model_q.size(); i++) begin
      if (e[15:0] > model_q[i][15:0]) begin pos = i; break; end
    end
    model_q.insert(pos, e);
    if (model_q.size() > 16) void'(model_q.pop_back());
  endtask

  // Compare process: readout beats, hold stability and count, every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_valid) begin
        if (expect_q.size() == 0) begin
          check("unexpected_beat", 32'(m_valid), 32'd0);
        end else begin
          check("beat_data", 32'(m_data), 32'(expect_q[0]));
          check("beat_index", 32'(m_index), 32'(exp_idx));
          check("beat_last", 32'(m_last), 32'(expect_q.size() == 1));
          if (m_ready) begin
            got_q.push_back(m_data);
            void'(expect_q.pop_front());
            exp_idx++;
          end
        end
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", {2'b0, m_index, m_last, m_data}, prev_word);
      end
      if (sync) check("count", 32'(count), 32'(model_q.size()));
    end
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_word  = {2'b0, m_index, m_last, m_data};
  end

  // Waits (bounded) for the controller to go idle while driving m_ready.
  // mode 0: always ready, 1: stall the first beat 3 cycles, 2: random.
  task automatic drain(input int mode, output int cycles);
    bit done = 0;
    int stall = 0;
    cycles = 0;
    for (int k = 0; k < 400; k++) begin
      if (mode == 1) begin
        if (m_valid && stall < 3) begin m_ready = 1'b0; stall++; end
        else m_ready = 1'b1;
      end else if (mode == 2) begin
        m_ready = 1'($urandom_range(0, 1));
      end else begin
        m_ready = 1'b1;
      end
      @(posedge clk); #1;
      cycles++;
      if (!busy) begin done = 1; break; end
    end
    m_ready = 1'b0;
    check("drain_timeout", 32'(done), 32'd1);
    check("readout_complete", 32'(expect_q.size()), 32'd0);
  endtask

  task automatic readout(input int mode, output int cycles);
    expect_q = model_q;
    exp_idx  = 0;
    got_q    = {};
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    drain(mode, cycles);
  endtask

  task automatic clear_frame();
    frame_start = 1'b1;
    #1;
    check("fs_blocks_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    model_q = {};
    check("overrun", 32'(overrun), 32'(exp_overrun));
  endtask

  // Offers one sample; fe_at/fs_at pulse frame_end/frame_start k cycles
  // after the accept (0 = no pulse).
  task automatic send(input logic [8:0] bin, input logic [15:0] mag,
                      input int fe_at = 0, input int fs_at = 0);
    bit ok = 0;
    bit drop;
    int cyc;
    for (int k = 0; k < 50; k++) begin
      if (s_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    check("ready_wait", 32'(ok), 32'd1);
    if (!ok) return;
    drop = (model_q.size() == 16) && (mag <= model_q[15][15:0]);
    s_valid = 1'b1;
    s_data  = {bin, mag};
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (drop) begin
      check("drop_ready", 32'(s_ready), 32'd1);
      return;
    end
    sync = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      frame_end   = (k == fe_at);
      frame_start = (k == fs_at);
      #1;
      check("insert_ready", 32'(s_ready), 32'(k == 7 && fe_at == 0));
      check("no_early_dump", 32'(m_valid), 32'd0);
    end
    frame_end   = 1'b0;
    frame_start = 1'b0;
    model_insert({bin, mag});
    sync = 1;
    if (fs_at != 0) begin
      exp_overrun = 1;
      check("overrun_set", 32'(overrun), 32'd1);
    end
    if (fe_at != 0) begin
      expect_q = model_q;
      exp_idx  = 0;
      got_q    = {};
      drain(0, cyc);
    end
  endtask

  initial begin
    int cyc;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_outs", {2'b0, m_index, m_last, m_data}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    mon_en = 1;
    sync   = 1;

    // Empty readout.
    readout(0, cyc);
    check("empty_busy_cycles", 32'(cyc <= 2), 32'd1);
    check("empty_got", 32'(got_q.size()), 32'd0);

    // Ordering.
    send(9'd1, 16'd5);
    send(9'd2, 16'd9);
    send(9'd3, 16'd7);
    readout(0, cyc);
    check("order_n", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("order_0", 32'(got_q[0][24:16]), 32'd2);
      check("order_1", 32'(got_q[1][24:16]), 32'd3);
      check("order_2", 32'(got_q[2][24:16]), 32'd1);
    end
    check("order_count", 32'(count), 32'd3);

    // Saturation: 1..20 keeps 20 down to 5.
    clear_frame();
    for (int i = 1; i <= 20; i++) send(9'(i), 16'(i));
    readout(0, cyc);
    check("sat_n", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      check("sat_first", 32'(got_q[0][15:0]), 32'd20);
      check("sat_last", 32'(got_q[15][15:0]), 32'd5);
    end
    check("sat_count", 32'(count), 32'd16);

    // Drop an equal-to-minimum sample, then insert at the bottom edge.
    send(9'd30, 16'd5);
    check("drop_count", 32'(count), 32'd16);
    send(9'd31, 16'd6);
    readout(0, cyc);
    if (got_q.size() == 16) check("edge_insert", 32'(got_q[15]), 32'({9'd31, 16'd6}));
    else check("edge_n", 32'(got_q.size()), 32'd16);

    // Ties keep arrival order.
    clear_frame();
    send(9'd1, 16'd7);
    send(9'd2, 16'd7);
    readout(0, cyc);
    check("tie_n", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("tie_0", 32'(got_q[0][24:16]), 32'd1);
      check("tie_1", 32'(got_q[1][24:16]), 32'd2);
    end

    // frame_end and an ignored frame_start during the search.
    clear_frame();
    send(9'd1, 16'd10);
    send(9'd2, 16'd20);
    send(9'd3, 16'd15, 2, 3);
    check("mid_fe_n", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) check("mid_fe_1", 32'(got_q[1][24:16]), 32'd3);

    // Back-pressure on the first beat.
    readout(1, cyc);

    // Reset in the middle of a readout.
    expect_q = model_q;
    exp_idx  = 0;
    got_q    = {};
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    m_ready   = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (got_q.size() >= 1) begin seen = 1; break; end
    end
    check("mid_dump_reached", 32'(seen), 32'd1);
    mon_en = 0;
    sync   = 0;
    reset  = 1'b1;
    @(posedge clk); #1;
    check("rst_dump_valid", 32'(m_valid), 32'd0);
    check("rst_dump_count", 32'(count), 32'd0);
    check("rst_dump_overrun", 32'(overrun), 32'd0);
    reset    = 1'b0;
    m_ready  = 1'b0;
    model_q  = {};
    expect_q = {};
    exp_overrun = 0;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    mon_en = 1;
    sync   = 1;

    // Random traffic with narrow magnitudes to exercise ties and drops.
    for (int n = 0; n < 120; n++) begin
      int r = int'($urandom_range(0, 19));
      if (r == 0) readout(2, cyc);
      else if (r == 1) clear_frame();
      else if (r == 2) send(9'($urandom), 16'($urandom_range(0, 40)), int'($urandom_range(1, 6)), 0);
      else send(9'($urandom), 16'($urandom_range(0, 40)));
    end
    readout(2, cyc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/peak_table_ctrl.md
PEAK_TABLE_CTRL -- requirements
Module: peak_table_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port frame_start, input, 1 bit: pulse that clears the table.
REQ-004 SHALL have port s_valid, input, 1 bit: candidate sample valid.
REQ-005 SHALL have port s_ready, output, 1 bit: candidate can be accepted.
REQ-006 SHALL have port s_data, input, 25 bits: [24:16] bin index, [15:0] magnitude.
REQ-007 SHALL have port frame_end, input, 1 bit: pulse that requests a readout.
REQ-008 SHALL have port m_valid, output, 1 bit: readout entry valid.
REQ-009 SHALL have port m_ready, input, 1 bit: consumer accepts the entry.
REQ-010 SHALL have port m_data, output, 25 bits: table entry, same layout as s_data.
REQ-011 SHALL have port m_index, output, 4 bits: rank of the entry (0 = largest).
REQ-012 SHALL have port m_last, output, 1 bit: final entry of the readout.
REQ-013 SHALL have port count, output, 5 bits: number of valid entries, 0..16.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than S_IDLE, or while a readout is pending.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag for an ignored frame_start.

Function
REQ-016 SHALL keep a 16-entry table sorted by magnitude[15:0] in descending order; entries at index count and above are don't-care.
REQ-017 SHALL implement the states S_IDLE, S_SEARCH, S_INSERT and S_DUMP.
REQ-018 SHALL drive s_ready=1 only in S_IDLE with no pending readout and frame_start=0.
REQ-019 On a handshake (s_valid & s_ready), SHALL latch s_data and apply the drop rule:
- if count==16 and magnitude <= table[15] magnitude, drop the sample and stay in S_IDLE;
- otherwise go to S_SEARCH.
REQ-020 S_SEARCH SHALL run a binary search for exactly 5 cycles over the range lo=0, hi=count.
REQ-021 The search result p SHALL be the lowest index where sample magnitude > table[p] magnitude, or p=count if there is no such index.
REQ-022 Equal magnitudes SHALL insert after existing entries, so the older entry keeps the higher rank.
REQ-023 S_INSERT (1 cycle) SHALL perform the insertion:
- shift entries p..14 to p+1..15 and discard entry 15;
- write the sample to entry p;
- increment count, saturating at 16;
- return to S_IDLE.
REQ-024 For an inserted sample accepted at cycle t, s_ready SHALL be 0 for cycles t+1..t+6 and 1 again at t+7.
REQ-025 For a dropped sample, s_ready SHALL stay 1 at t+1, giving a throughput of 1 sample/cycle.
REQ-026 frame_end SHALL set a pending flag in any state; an accept and a frame_end in the same cycle SHALL complete the insert before the readout.
REQ-027 In S_IDLE with the pending flag set, SHALL clear the flag and enter S_DUMP.
REQ-028 S_DUMP SHALL emit entries 0..count-1 in order:
- m_data, m_index and m_last stay stable while m_valid=1 and m_ready=0;
- the index advances on each handshake;
- m_last=1 on entry count-1;
- return to S_IDLE after the last handshake.
REQ-029 With count==0, S_DUMP SHALL emit nothing and return to S_IDLE on the next cycle.
REQ-030 A readout SHALL NOT modify the table or count.
REQ-031 frame_start in S_IDLE with no pending readout SHALL set count=0 that cycle and accept no sample.
REQ-032 frame_start in any other condition SHALL be ignored and set overrun=1.

Reset
REQ-033 Reset SHALL force S_IDLE, count=0, all table entries=0, and the pending flag and overrun cleared.
REQ-034 Reset SHALL force m_valid=0, m_last=0, m_index=0 and m_data=0; s_ready SHALL be 1 on the first cycle after reset when s_ready's conditions are met.
REQ-035 Reset SHALL take priority over all inputs, including in the middle of S_SEARCH, S_INSERT or S_DUMP.

Structure
REQ-036 Package peak_pkg SHALL hold ENTRY_W=25, MAG_W=16, DEPTH=16, SEARCH_CYCLES=5, the state enum, and the entry typedef with fields bin and mag.
REQ-037 SHALL be implemented as a single module with no sub-module; the search and shift logic are inline.

Verification
REQ-038 Empty readout: reset, then frame_end -> no m_valid; busy=0 within 2 cycles; count=0.
REQ-039 Ordering: insert magnitudes 5, 9, 7 (bins 1, 2, 3) then frame_end -> readout bins 2, 3, 1; m_index 0, 1, 2; m_last on the third entry; count=3.
REQ-040 Saturation: insert magnitudes 1..20 then readout -> 20 down to 5; count=16.
REQ-041 Drop and edge insert: full table with minimum 5; send 5 -> dropped and s_ready=1 next cycle; send 6 -> lands at index 15.
REQ-042 Ties: magnitude 7 bin 1, then magnitude 7 bin 2 -> bin 1 at a lower index than bin 2.
REQ-043 Stress:
- frame_end during S_SEARCH -> readout starts after S_INSERT;
- m_ready=0 for 3 cycles -> m_data held stable;
- reset mid-dump -> m_valid=0 and count=0 on the next cycle.
